tpu_instr_dispatcher: RTL and testbench
=======================================

# tpu_instr_dispatcher

Single-issue instruction dispatcher for the TPU: buffers one incoming instruction, decodes its opcode and forwards it to the weight, matrix-multiply or activation unit, or executes a synchronize barrier. It sits between the instruction FIFO and the three execution units. It stalls upstream through `busy` while the target unit is occupied.

## Interface
- No parameters; field widths come from the shared package.
- Reset is synchronous and active-high on `rst`; single clock `clk`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `enable` in 1: global enable; 0 freezes all state.
- `instr` in instr_type: opcode[7:0], length[31:0], acc_addr[15:0], buffer_addr[23:0].
- `instr_enable` in 1: `instr` valid this cycle.
- `busy` out 1: coordinator cannot accept an instruction.
- `weight_busy`, `matrix_busy`, `activation_busy` in 1 each: unit is executing.
- `weight_resource_busy`, `matrix_resource_busy`, `activation_resource_busy` in 1 each: unit still holds shared resources. Used only for synchronize. Benches tie these low when unused.
- `weight_instr` out weight_instr_type: opcode, length, weight_addr[39:0] = {acc_addr, buffer_addr}.
- `weight_instr_enable` out 1: one-cycle dispatch strobe.
- `matrix_instr`, `activation_instr` out instr_type.
- `matrix_instr_enable`, `activation_instr_enable` out 1: one-cycle dispatch strobes.
- `synchronize` out 1: one-cycle pulse when the barrier completes.

## Operation
- Holding register `hold` plus valid bit `hv`.
- Accept rule: `enable & instr_enable & ~busy` loads `instr` into `hold` and sets `hv`. If `busy`=1, `instr_enable` is ignored; the instruction is lost and upstream must hold it.
- Decode of `hold.opcode`, in priority order:
  - 0xFF → SYNC.
  - [7:3]=00001 → WEIGHT.
  - [7:5]=001 → MATRIX.
  - [7]=1 → ACTIVATION.
  - anything else → NOP.
- Effective busy per unit: `x_eff = x_busy | x_instr_enable`. The strobe cycle counts as busy because units raise busy one cycle late.
- Dispatch (when `hv & enable`):
  - WEIGHT/MATRIX/ACTIVATION with target `x_eff`=0: register `hold` into `x_instr`, pulse `x_instr_enable`, clear `hv` unless refilled the same edge.
  - Target `x_eff`=1: stall and keep `hold`.
  - NOP: clear `hv`; no strobe.
  - SYNC: wait until every `x_eff` and every `x_resource_busy` is 0, then pulse `synchronize` and clear `hv`.
- `busy` = `hv & ~(dispatch or complete this cycle)`, combinational. A dispatching cycle accepts the next instruction, giving back-to-back throughput of 1 per cycle across different units.
- `x_instr` holds its last dispatched value between strobes.
- `enable`=0: no accept, no dispatch; strobes and `synchronize` forced to 0; registers keep their values.

## Timing
- Reset values:
  - `hv`=0, `hold`=INIT_INSTR.
  - All `*_instr` = INIT_INSTR (all zero).
  - All strobes and `synchronize` = 0.
  - `busy`=0.
- Latency: `instr_enable` sampled at edge N → `hold` valid in cycle N+1 → strobe high in cycle N+2 if the target is free.
- Same-unit instructions back to back: the second dispatches no earlier than 2 cycles after the first strobe, since the strobe itself is counted as busy.
- Reset overrides `enable` and `instr_enable` on the same edge. Reset mid-stall drops the held instruction.
- `busy` and the decode are combinational from registers and unit busy inputs. All other outputs are registered.

## Structure
- `tpu_pkg` holds:
  - `instr_type` and `weight_instr_type`.
  - `INIT_INSTR` and `INIT_WEIGHT_INSTR` (all zero).
  - Opcode constants: OP_SYNC=8'hFF, weight/matrix prefix masks.
- Optional sub-module `instr_decoder`: combinational opcode → {weight, matrix, activation, sync, nop}. Everything else stays in one module.

## Test plan
- Reset, then opcode 0x08, length 0x500, acc_addr 0x0A30, units idle → `weight_instr_enable` high exactly one cycle, 2 cycles after sampling, with weight_addr[39:24]=0x0A30, length 0x500. Other strobes stay 0.
- `weight_busy`=1, send weight instruction length 0x47100 → `busy`=1 and no strobe. Drop `weight_busy` → strobe the next cycle and `busy` falls.
- Two weight instructions on consecutive cycles (length 0x500, then 0x95900) → two strobes separated by ≥2 cycles, in order, correct lengths.
- Opcodes 0x28 and 0x21 → `matrix_instr_enable`. Opcodes 0xA8 and 0x81 → `activation_instr_enable`. Repeat the stall checks for each unit.
- Consecutive 0x08, 0x20, 0x80 with idle units → three strobes on consecutive cycles, no `busy`.
- 0xFF while `matrix_busy`=1 → `busy` held and `synchronize`=0. Release `matrix_busy` → one `synchronize` pulse.
- 0x00 → no strobes, `hv` clears after 1 cycle.
- `enable`=0 mid-stall → state frozen.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU instruction path.
//   instr_type        : raw instruction as it leaves the instruction FIFO
//   weight_instr_type : instruction as seen by the weight unit, with the
//                       accumulator and buffer addresses fused into one
//                       40-bit weight address
package tpu_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] length;
    logic [15:0] acc_addr;
    logic [23:0] buffer_addr;
  } instr_type;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] length;
    logic [39:0] weight_addr;
  } weight_instr_type;

  localparam instr_type        INIT_INSTR        = '0;
  localparam weight_instr_type INIT_WEIGHT_INSTR = '0;

  // Opcode classes, checked in this priority order: sync, weight, matrix,
  // activation, otherwise nop.
  localparam logic [7:0] OP_SYNC        = 8'hFF;
  localparam logic [7:0] OP_WEIGHT_MASK = 8'hF8;
  localparam logic [7:0] OP_WEIGHT_VAL  = 8'h08;
  localparam logic [7:0] OP_MATRIX_MASK = 8'hE0;
  localparam logic [7:0] OP_MATRIX_VAL  = 8'h20;
  localparam logic [7:0] OP_ACT_MASK    = 8'h80;
  localparam logic [7:0] OP_ACT_VAL     = 8'h80;

  function automatic weight_instr_type to_weight_instr(input instr_type i);
    weight_instr_type w;
    w.opcode      = i.opcode;
    w.length      = i.length;
    w.weight_addr = {i.acc_addr, i.buffer_addr};
    return w;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier. Exactly one output is high for any opcode.
//   opcode_i      : opcode of the held instruction
//   is_sync_o     : synchronize barrier
//   is_weight_o   : weight-unit instruction
//   is_matrix_o   : matrix-multiply instruction
//   is_act_o      : activation instruction
//   is_nop_o      : no recognised target, retired without a strobe
module instr_decoder
  import tpu_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic       is_sync_o,
  output logic       is_weight_o,
  output logic       is_matrix_o,
  output logic       is_act_o,
  output logic       is_nop_o
);

  always_comb begin
    is_sync_o   = 1'b0;
    is_weight_o = 1'b0;
    is_matrix_o = 1'b0;
    is_act_o    = 1'b0;
    is_nop_o    = 1'b0;
    // 0xFF also has bit 7 set, so sync must win over activation.
    if (opcode_i == OP_SYNC)
      is_sync_o = 1'b1;
    else if ((opcode_i & OP_WEIGHT_MASK) == OP_WEIGHT_VAL)
      is_weight_o = 1'b1;
    else if ((opcode_i & OP_MATRIX_MASK) == OP_MATRIX_VAL)
      is_matrix_o = 1'b1;
    else if ((opcode_i & OP_ACT_MASK) == OP_ACT_VAL)
      is_act_o = 1'b1;
    else
      is_nop_o = 1'b1;
  end

endmodule

// File: rtl/tpu_instr_dispatcher.sv
// Single-issue instruction dispatcher. One instruction is buffered in a
// holding register, decoded, and forwarded to the weight, matrix or
// activation unit once that unit is free; 0xFF waits for all units to go
// idle and release their resources, then pulses synchronize.
//   clk, rst                    : clock, synchronous active-high reset
//   enable                      : global enable, 0 freezes all state
//   instr, instr_enable         : incoming instruction and its valid
//   busy                        : cannot accept an instruction this cycle
//   *_busy                      : unit executing
//   *_resource_busy             : unit holds shared resources (sync only)
//   weight/matrix/activation_instr(_enable) : dispatched instruction + strobe
//   synchronize                 : one-cycle pulse when a barrier completes
module tpu_instr_dispatcher
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  instr_type        instr,
  input  logic             instr_enable,
  output logic             busy,
  input  logic             weight_busy,
  input  logic             matrix_busy,
  input  logic             activation_busy,
  input  logic             weight_resource_busy,
  input  logic             matrix_resource_busy,
  input  logic             activation_resource_busy,
  output weight_instr_type weight_instr,
  output logic             weight_instr_enable,
  output instr_type        matrix_instr,
  output logic             matrix_instr_enable,
  output instr_type        activation_instr,
  output logic             activation_instr_enable,
  output logic             synchronize
);

  instr_type        hold_q, hold_d;
  logic             hv_q, hv_d;
  weight_instr_type weight_instr_q, weight_instr_d;
  instr_type        matrix_instr_q, matrix_instr_d;
  instr_type        act_instr_q, act_instr_d;
  logic             weight_en_q, weight_en_d;
  logic             matrix_en_q, matrix_en_d;
  logic             act_en_q, act_en_d;
  logic             sync_q, sync_d;

  logic is_sync, is_weight, is_matrix, is_act, is_nop;
  logic w_eff, m_eff, a_eff;
  logic go, disp_w, disp_m, disp_a, sync_done, nop_done, done, accept;

  instr_decoder u_decoder (
    .opcode_i    (hold_q.opcode),
    .is_sync_o   (is_sync),
    .is_weight_o (is_weight),
    .is_matrix_o (is_matrix),
    .is_act_o    (is_act),
    .is_nop_o    (is_nop)
  );

  always_comb begin
    // Units raise busy one cycle after the strobe, so the strobe cycle
    // itself must be treated as busy to avoid a double dispatch.
    w_eff = weight_busy | weight_en_q;
    m_eff = matrix_busy | matrix_en_q;
    a_eff = activation_busy | act_en_q;

    go        = hv_q & enable;
    disp_w    = go & is_weight & ~w_eff;
    disp_m    = go & is_matrix & ~m_eff;
    disp_a    = go & is_act & ~a_eff;
    sync_done = go & is_sync & ~(w_eff | m_eff | a_eff |
                weight_resource_busy | matrix_resource_busy |
                activation_resource_busy);
    nop_done  = go & is_nop;
    done      = disp_w | disp_m | disp_a | sync_done | nop_done;

    // A retiring cycle frees the holding register for the next instruction,
    // giving one instruction per cycle when targets differ.
    busy   = hv_q & ~done;
    accept = enable & instr_enable & ~busy;

    hv_d   = hv_q;
    hold_d = hold_q;
    if (accept) begin
      hv_d   = 1'b1;
      hold_d = instr;
    end else if (done) begin
      hv_d = 1'b0;
    end

    weight_instr_d = disp_w ? to_weight_instr(hold_q) : weight_instr_q;
    matrix_instr_d = disp_m ? hold_q : matrix_instr_q;
    act_instr_d    = disp_a ? hold_q : act_instr_q;

    // Strobes fall to zero whenever enable is low since disp_* include it.
    weight_en_d = disp_w;
    matrix_en_d = disp_m;
    act_en_d    = disp_a;
    sync_d      = sync_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q         <= INIT_INSTR;
      hv_q           <= 1'b0;
      weight_instr_q <= INIT_WEIGHT_INSTR;
      matrix_instr_q <= INIT_INSTR;
      act_instr_q    <= INIT_INSTR;
      weight_en_q    <= 1'b0;
      matrix_en_q    <= 1'b0;
      act_en_q       <= 1'b0;
      sync_q         <= 1'b0;
    end else begin
      hold_q         <= hold_d;
      hv_q           <= hv_d;
      weight_instr_q <= weight_instr_d;
      matrix_instr_q <= matrix_instr_d;
      act_instr_q    <= act_instr_d;
      weight_en_q    <= weight_en_d;
      matrix_en_q    <= matrix_en_d;
      act_en_q       <= act_en_d;
      sync_q         <= sync_d;
    end
  end

  assign weight_instr            = weight_instr_q;
  assign weight_instr_enable     = weight_en_q;
  assign matrix_instr            = matrix_instr_q;
  assign matrix_instr_enable     = matrix_en_q;
  assign activation_instr        = act_instr_q;
  assign activation_instr_enable = act_en_q;
  assign synchronize             = sync_q;

endmodule

// File: tb/tb_tpu_instr_dispatcher.sv
// Directed bench for tpu_instr_dispatcher. Inputs change 1ns after the rising
// edge, outputs are observed on the falling edge. Every strobe seen is logged
// with its unit id (0 weight, 1 matrix, 2 activation, 3 synchronize), the
// cycle index and the length, and the log is compared to hand-derived values.
// Cycle index: cyc_n becomes N at rising edge N; an instruction sampled at
// edge s sits in hold during cycle s and strobes during cycle s+1.
module tb_tpu_instr_dispatcher;
  import tpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  instr_type        instr;
  logic             instr_enable;
  logic             busy;
  logic             weight_busy, matrix_busy, activation_busy;
  logic             weight_resource_busy, matrix_resource_busy, activation_resource_busy;
  weight_instr_type weight_instr;
  logic             weight_instr_enable;
  instr_type        matrix_instr;
  logic             matrix_instr_enable;
  instr_type        activation_instr;
  logic             activation_instr_enable;
  logic             synchronize;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  int          log_unit[$];
  int          log_cyc[$];
  logic [31:0] log_len[$];
  logic [39:0] log_waddr[$];
  int          busy_seen;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  tpu_instr_dispatcher dut (
    .clk                      (clk),
    .rst                      (rst),
    .enable                   (enable),
    .instr                    (instr),
    .instr_enable             (instr_enable),
    .busy                     (busy),
    .weight_busy              (weight_busy),
    .matrix_busy              (matrix_busy),
    .activation_busy          (activation_busy),
    .weight_resource_busy     (weight_resource_busy),
    .matrix_resource_busy     (matrix_resource_busy),
    .activation_resource_busy (activation_resource_busy),
    .weight_instr             (weight_instr),
    .weight_instr_enable      (weight_instr_enable),
    .matrix_instr             (matrix_instr),
    .matrix_instr_enable      (matrix_instr_enable),
    .activation_instr         (activation_instr),
    .activation_instr_enable  (activation_instr_enable),
    .synchronize              (synchronize)
  );

  always @(negedge clk) begin
    if (busy) busy_seen++;
    if (weight_instr_enable) begin
      log_unit.push_back(0); log_cyc.push_back(cyc_n);
      log_len.push_back(weight_instr.length); log_waddr.push_back(weight_instr.weight_addr);
    end
    if (matrix_instr_enable) begin
      log_unit.push_back(1); log_cyc.push_back(cyc_n);
      log_len.push_back(matrix_instr.length); log_waddr.push_back(40'd0);
    end
    if (activation_instr_enable) begin
      log_unit.push_back(2); log_cyc.push_back(cyc_n);
      log_len.push_back(activation_instr.length); log_waddr.push_back(40'd0);
    end
    if (synchronize) begin
      log_unit.push_back(3); log_cyc.push_back(cyc_n);
      log_len.push_back(32'd0); log_waddr.push_back(40'd0);
    end
  end

  task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) to_drive();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_log();
    log_unit.delete(); log_cyc.delete(); log_len.delete(); log_waddr.delete();
    busy_seen = 0;
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] len,
                      input logic [15:0] acc, input logic [23:0] ba, output int s);
    instr.opcode      = op;
    instr.length      = len;
    instr.acc_addr    = acc;
    instr.buffer_addr = ba;
    instr_enable      = 1'b1;
    to_drive();
    s = cyc_n;
    instr_enable = 1'b0;
  endtask

  task automatic set_unit_busy(input int u, input logic v);
    case (u)
      0:       weight_busy     = v;
      1:       matrix_busy     = v;
      default: activation_busy = v;
    endcase
  endtask

  task automatic check_count(input string tag, input int n);
    check_val({tag, "_count"}, 96'(log_unit.size()), 96'(n));
  endtask

  task automatic check_event(input string tag, input int idx, input int unit,
                             input int cyc, input logic [31:0] len);
    if (idx < log_unit.size()) begin
      check_val({tag, "_unit"}, 96'(log_unit[idx]), 96'(unit));
      check_val({tag, "_cycle"}, 96'(log_cyc[idx]), 96'(cyc));
      check_val({tag, "_len"}, 96'(log_len[idx]), 96'(len));
    end else begin
      check_val({tag, "_present"}, 96'(log_unit.size()), 96'(idx + 1));
    end
  endtask

  task automatic stall_unit(input string tag, input int u, input logic [7:0] op,
                            input logic [31:0] len);
    int s, r;
    clear_log();
    set_unit_busy(u, 1'b1);
    send(op, len, 16'h0001, 24'h000002, s);
    idle(2);
    sample();
    check_val({tag, "_stall_busy"}, 96'(busy), 96'(1));
    check_count({tag, "_stall"}, 0);
    to_drive();
    set_unit_busy(u, 1'b0);
    r = cyc_n;
    sample();
    check_val({tag, "_release_busy"}, 96'(busy), 96'(0));
    idle(3);
    check_count({tag, "_release"}, 1);
    check_event({tag, "_release"}, 0, u, r + 1, len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, r;
    logic [7:0] ops[4];
    int         units[4];
    logic [7:0] nops[4];

    rst = 1'b1; enable = 1'b1; instr = INIT_INSTR; instr_enable = 1'b0;
    weight_busy = 1'b0; matrix_busy = 1'b0; activation_busy = 1'b0;
    weight_resource_busy = 1'b0; matrix_resource_busy = 1'b0; activation_resource_busy = 1'b0;
    idle(2);
    sample();
    check_val("rst_busy", 96'(busy), 96'(0));
    check_val("rst_strobes", 96'({weight_instr_enable, matrix_instr_enable,
              activation_instr_enable, synchronize}), 96'(0));
    check_val("rst_weight_instr", 96'(weight_instr), 96'(0));
    check_val("rst_matrix_instr", 96'(matrix_instr), 96'(0));
    check_val("rst_act_instr", 96'(activation_instr), 96'(0));
    to_drive();
    rst = 1'b0;
    idle(1);

    // Basic weight dispatch, two cycles after sampling.
    clear_log();
    send(8'h08, 32'h500, 16'h0A30, 24'h123456, s);
    idle(3);
    check_count("w_basic", 1);
    check_event("w_basic", 0, 0, s + 1, 32'h500);
    if (log_waddr.size() > 0)
      check_val("w_basic_addr", 96'(log_waddr[0]), 96'(40'h0A30_123456));
    check_val("w_basic_hold_op", 96'(weight_instr.opcode), 96'(8'h08));
    check_val("w_basic_busy", 96'(busy_seen), 96'(0));

    // Stall on each unit, released by dropping its busy input.
    stall_unit("w_stall", 0, 8'h08, 32'h47100);
    stall_unit("m_stall", 1, 8'h28, 32'h1234);
    stall_unit("a_stall", 2, 8'hA8, 32'h5678);

    // Two weight instructions back to back: the strobe cycle blocks the second.
    clear_log();
    send(8'h08, 32'h500, 16'h0, 24'h0, s);
    send(8'h08, 32'h95900, 16'h0, 24'h0, s2);
    idle(4);
    check_count("w_b2b", 2);
    check_event("w_b2b0", 0, 0, s + 1, 32'h500);
    check_event("w_b2b1", 1, 0, s + 3, 32'h95900);

    // Opcode classes for matrix and activation.
    ops[0] = 8'h28; units[0] = 1;
    ops[1] = 8'h21; units[1] = 1;
    ops[2] = 8'hA8; units[2] = 2;
    ops[3] = 8'h81; units[3] = 2;
    for (int i = 0; i < 4; i++) begin
      clear_log();
      send(ops[i], 32'h100 + 32'(i), 16'h0, 24'h0, s);
      idle(3);
      check_count($sformatf("class_%0h", ops[i]), 1);
      check_event($sformatf("class_%0h", ops[i]), 0, units[i], s + 1, 32'h100 + 32'(i));
    end

    // Different units back to back: one per cycle, never busy.
    clear_log();
    send(8'h08, 32'h11, 16'h0, 24'h0, s);
    send(8'h20, 32'h22, 16'h0, 24'h0, s2);
    send(8'h80, 32'h33, 16'h0, 24'h0, s2);
    idle(3);
    check_count("mix", 3);
    check_event("mix0", 0, 0, s + 1, 32'h11);
    check_event("mix1", 1, 1, s + 2, 32'h22);
    check_event("mix2", 2, 2, s + 3, 32'h33);
    check_val("mix_busy", 96'(busy_seen), 96'(0));

    // Synchronize: waits for matrix_busy, then for a resource busy.
    clear_log();
    matrix_busy = 1'b1;
    send(8'hFF, 32'h0, 16'h0, 24'h0, s);
    idle(2);
    sample();
    check_val("sync_wait_busy", 96'(busy), 96'(1));
    check_count("sync_wait", 0);
    to_drive();
    matrix_busy = 1'b0;
    weight_resource_busy = 1'b1;
    sample();
    check_val("sync_res_busy", 96'(busy), 96'(1));
    idle(2);
    check_count("sync_res", 0);
    weight_resource_busy = 1'b0;
    r = cyc_n;
    sample();
    check_val("sync_release_busy", 96'(busy), 96'(0));
    idle(3);
    check_count("sync_done", 1);
    check_event("sync_done", 0, 3, r + 1, 32'h0);

    // Opcodes with no target retire in one cycle without a strobe.
    nops[0] = 8'h00; nops[1] = 8'h10; nops[2] = 8'h07; nops[3] = 8'h7F;
    for (int i = 0; i < 4; i++) begin
      clear_log();
      send(nops[i], 32'hABC, 16'h0, 24'h0, s);
      sample();
      check_val($sformatf("nop_%0h_hv", nops[i]), 96'(dut.hv_q), 96'(1));
      check_val($sformatf("nop_%0h_busy", nops[i]), 96'(busy), 96'(0));
      to_drive();
      sample();
      check_val($sformatf("nop_%0h_hv_clr", nops[i]), 96'(dut.hv_q), 96'(0));
      idle(2);
      check_count($sformatf("nop_%0h", nops[i]), 0);
    end
    clear_log();
    send(8'h00, 32'h0, 16'h0, 24'h0, s);
    send(8'h08, 32'h66, 16'h0, 24'h0, s2);
    idle(3);
    check_count("nop_then_w", 1);
    check_event("nop_then_w", 0, 0, s + 2, 32'h66);

    // enable=0 during a stall freezes everything even after the unit frees.
    clear_log();
    weight_busy = 1'b1;
    send(8'h08, 32'h777, 16'h0, 24'h0, s);
    idle(1);
    enable = 1'b0;
    weight_busy = 1'b0;
    sample();
    check_val("freeze_busy0", 96'(busy), 96'(1));
    idle(3);
    check_count("freeze", 0);
    sample();
    check_val("freeze_busy1", 96'(busy), 96'(1));
    to_drive();
    enable = 1'b1;
    r = cyc_n;
    idle(3);
    check_count("unfreeze", 1);
    check_event("unfreeze", 0, 0, r + 1, 32'h777);

    // Reset mid-stall drops the held instruction and clears the outputs.
    clear_log();
    weight_busy = 1'b1;
    send(8'h08, 32'h999, 16'h0, 24'h0, s);
    idle(1);
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    weight_busy = 1'b0;
    idle(3);
    sample();
    check_count("rst_stall", 0);
    check_val("rst_stall_busy", 96'(busy), 96'(0));
    check_val("rst_stall_hv", 96'(dut.hv_q), 96'(0));
    check_val("rst_stall_winstr", 96'(weight_instr), 96'(0));
    check_val("rst_stall_minstr", 96'(matrix_instr), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
